// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and packet check for the UART command controller.
package uart_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] ACK       = 8'h06;
   localparam logic [7:0] NAK       = 8'h15;
   localparam logic [7:0] CMD_SET   = 8'h01;
   localparam logic [7:0] CMD_XOR   = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;

   typedef enum logic [2:0] {
      IDLE,
      GET_CMD,
      GET_DATA,
      GET_CHK,
      EXEC,
      RESP
   } state_t;

   // A packet is acted upon only if the checksum matches and the command is known.
   function automatic logic pkt_valid(input logic [7:0] cmd, input logic [7:0] data,
                                      input logic [7:0] chk);
      return (chk == (cmd ^ data)) &&
             ((cmd == CMD_SET) || (cmd == CMD_XOR) || (cmd == CMD_READ));
   endfunction

endpackage

// File: rtl/uart_cmd_ctrl.sv
// Parses A5/CMD/DATA/CHK packets from a UART receiver, drives an LED register
// and returns a one-byte ACK/NAK/readback response; aborts on frame error or timeout.
module uart_cmd_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_rdsig,
   input  logic       rx_frameerr,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic [7:0] led,
   output logic       pkt_ok,
   output logic       pkt_err
);

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   state_t        state_q;
   logic          rdsig_q;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    cmd_q, data_q, chk_q, led_q, tx_data_q;
   logic          tx_start_q, pkt_ok_q, pkt_err_q;
   logic          byte_stb, in_get, tmo_expire;

   assign byte_stb   = rx_rdsig & ~rdsig_q;
   assign in_get     = (state_q == GET_CMD) || (state_q == GET_DATA) || (state_q == GET_CHK);
   assign tmo_expire = in_get && !byte_stb && (tmo_q == TMO_LAST);

   // Saturating counter; a byte always restarts it, so byte_stb beats expiry.
   always_comb begin
      tmo_d = tmo_q;
      if (byte_stb || !in_get)
         tmo_d = '0;
      else if (tmo_q != TMO_LAST)
         tmo_d = tmo_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rdsig_q    <= 1'b1;
         tmo_q      <= '0;
         cmd_q      <= 8'h00;
         data_q     <= 8'h00;
         chk_q      <= 8'h00;
         led_q      <= 8'h00;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         pkt_ok_q   <= 1'b0;
         pkt_err_q  <= 1'b0;
      end else begin
         rdsig_q    <= rx_rdsig;
         tmo_q      <= tmo_d;
         tx_start_q <= 1'b0;
         pkt_ok_q   <= 1'b0;
         pkt_err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (byte_stb && !rx_frameerr && (rx_data == SYNC_BYTE))
                  state_q <= GET_CMD;
            end
            GET_CMD, GET_DATA, GET_CHK: begin
               if (byte_stb) begin
                  if (rx_frameerr) begin
                     state_q   <= IDLE;
                     pkt_err_q <= 1'b1;
                  end else begin
                     case (state_q)
                        GET_CMD: begin
                           cmd_q   <= rx_data;
                           state_q <= GET_DATA;
                        end
                        GET_DATA: begin
                           data_q  <= rx_data;
                           state_q <= GET_CHK;
                        end
                        default: begin
                           // Status is decided here so the pulse lines up with the EXEC cycle.
                           chk_q     <= rx_data;
                           pkt_ok_q  <= pkt_valid(cmd_q, data_q, rx_data);
                           pkt_err_q <= !pkt_valid(cmd_q, data_q, rx_data);
                           state_q   <= EXEC;
                        end
                     endcase
                  end
               end else if (tmo_expire) begin
                  state_q   <= IDLE;
                  pkt_err_q <= 1'b1;
               end
            end
            EXEC: begin
               tx_data_q <= NAK;
               if (pkt_valid(cmd_q, data_q, chk_q)) begin
                  case (cmd_q)
                     CMD_SET: begin
                        led_q     <= data_q;
                        tx_data_q <= ACK;
                     end
                     CMD_XOR: begin
                        led_q     <= led_q ^ data_q;
                        tx_data_q <= ACK;
                     end
                     default: tx_data_q <= led_q;
                  endcase
               end
               state_q <= RESP;
            end
            RESP: begin
               if (!tx_busy) begin
                  tx_start_q <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign led      = led_q;
   assign pkt_ok   = pkt_ok_q;
   assign pkt_err  = pkt_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: packets, NAK cases, timeout, busy stall, reset abort.
module tb_uart_cmd_ctrl;

   localparam int unsigned TMO = 300;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_rdsig = 1'b0;
   logic       rx_frameerr = 1'b0;
   logic       tx_busy = 1'b0;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [7:0] led;
   logic       pkt_ok;
   logic       pkt_err;

   int n_checks = 0;
   int n_errors = 0;

   int         tx_cnt = 0;
   int         ok_cnt = 0;
   int         err_cnt = 0;
   logic [7:0] last_tx = 8'h00;
   int         tx0, ok0, err0;

   uart_cmd_ctrl #(.TIMEOUT_CYC(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_rdsig    (rx_rdsig),
      .rx_frameerr (rx_frameerr),
      .tx_busy     (tx_busy),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .led         (led),
      .pkt_ok      (pkt_ok),
      .pkt_err     (pkt_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_start) begin
         tx_cnt  <= tx_cnt + 1;
         last_tx <= tx_data;
      end
      if (pkt_ok)  ok_cnt  <= ok_cnt + 1;
      if (pkt_err) err_cnt <= err_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic fe);
      @(negedge clk);
      rx_data     = b;
      rx_frameerr = fe;
      rx_rdsig    = 1'b1;
      @(negedge clk);
      rx_rdsig    = 1'b0;
      rx_frameerr = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
      send_byte(b0, 1'b0);
      send_byte(b1, 1'b0);
      send_byte(b2, 1'b0);
      send_byte(b3, 1'b0);
   endtask

   task automatic snap();
      @(negedge clk);
      tx0  = tx_cnt;
      ok0  = ok_cnt;
      err0 = err_cnt;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      settle(3);
      check("rst_led", led, 8'h00);
      check("rst_tx_start", tx_start, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_pkt_ok", pkt_ok, 1'b0);
      check("rst_pkt_err", pkt_err, 1'b0);
      rst = 1'b0;
      settle(3);

      // SET
      snap();
      send_pkt(8'hA5, 8'h01, 8'h3C, 8'h3D);
      settle(8);
      check("set_led", led, 8'h3C);
      check("set_ok", ok_cnt - ok0, 1);
      check("set_err", err_cnt - err0, 0);
      check("set_txcnt", tx_cnt - tx0, 1);
      check("set_txdata", last_tx, 8'h06);

      // READ then XOR
      snap();
      send_pkt(8'hA5, 8'h03, 8'h00, 8'h03);
      settle(8);
      check("read_txdata", last_tx, 8'h3C);
      check("read_ok", ok_cnt - ok0, 1);
      check("read_led", led, 8'h3C);
      snap();
      send_pkt(8'hA5, 8'h02, 8'hFF, 8'hFD);
      settle(8);
      check("xor_led", led, 8'hC3);
      check("xor_txdata", last_tx, 8'h06);
      check("xor_txcnt", tx_cnt - tx0, 1);

      // Bad checksum and unknown command
      snap();
      send_pkt(8'hA5, 8'h01, 8'h55, 8'h00);
      settle(8);
      check("badchk_led", led, 8'hC3);
      check("badchk_err", err_cnt - err0, 1);
      check("badchk_ok", ok_cnt - ok0, 0);
      check("badchk_txdata", last_tx, 8'h15);
      snap();
      send_pkt(8'hA5, 8'h07, 8'h11, 8'h16);
      settle(8);
      check("unk_led", led, 8'hC3);
      check("unk_err", err_cnt - err0, 1);
      check("unk_txcnt", tx_cnt - tx0, 1);
      check("unk_txdata", last_tx, 8'h15);

      // Inter-byte timeout: no early expiry, then expiry with no response
      snap();
      send_byte(8'hA5, 1'b0);
      send_byte(8'h01, 1'b0);
      settle(TMO - 5);
      check("tmo_early_err", err_cnt - err0, 0);
      settle(10);
      check("tmo_err", err_cnt - err0, 1);
      check("tmo_txcnt", tx_cnt - tx0, 0);
      check("tmo_led", led, 8'hC3);
      snap();
      send_pkt(8'hA5, 8'h01, 8'h5A, 8'h5B);
      settle(8);
      check("post_tmo_led", led, 8'h5A);
      check("post_tmo_ok", ok_cnt - ok0, 1);

      // Frame error mid-packet, then a frame-errored sync byte in IDLE is ignored
      snap();
      send_byte(8'hA5, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h3C, 1'b1);
      settle(4);
      check("fe_err", err_cnt - err0, 1);
      check("fe_txcnt", tx_cnt - tx0, 0);
      snap();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b0);
      send_byte(8'h3C, 1'b0);
      send_byte(8'h3D, 1'b0);
      settle(8);
      check("fe_idle_ok", ok_cnt - ok0, 0);
      check("fe_idle_err", err_cnt - err0, 0);
      check("fe_idle_led", led, 8'h5A);

      // A5 inside the packet is data
      snap();
      send_pkt(8'hA5, 8'h01, 8'hA5, 8'hA4);
      settle(8);
      check("a5data_led", led, 8'hA5);
      check("a5data_ok", ok_cnt - ok0, 1);

      // Long tx_busy stall with extra bytes arriving in RESP
      tx_busy = 1'b1;
      snap();
      send_pkt(8'hA5, 8'h02, 8'h0F, 8'h0D);
      send_pkt(8'hA5, 8'h01, 8'h00, 8'h01);
      settle(5000 - 24);
      check("busy_txcnt", tx_cnt - tx0, 0);
      check("busy_led", led, 8'hAA);
      tx_busy = 1'b0;
      settle(10);
      check("busy_rel_txcnt", tx_cnt - tx0, 1);
      check("busy_rel_txdata", last_tx, 8'h06);
      check("busy_ok", ok_cnt - ok0, 1);
      check("busy_err", err_cnt - err0, 0);
      check("busy_led_after", led, 8'hAA);

      // Reset mid-packet with rx_rdsig held high across release
      snap();
      send_byte(8'hA5, 1'b0);
      send_byte(8'h01, 1'b0);
      @(negedge clk);
      rx_data  = 8'hA5;
      rx_rdsig = 1'b1;
      rst      = 1'b1;
      settle(2);
      check("midrst_led", led, 8'h00);
      check("midrst_tx_data", tx_data, 8'h00);
      check("midrst_tx_start", tx_start, 1'b0);
      rst = 1'b0;
      settle(4);
      rx_rdsig = 1'b0;
      settle(2);
      send_byte(8'h01, 1'b0);
      send_byte(8'h3C, 1'b0);
      send_byte(8'h3D, 1'b0);
      settle(8);
      check("midrst_spurious_ok", ok_cnt - ok0, 0);
      check("midrst_spurious_tx", tx_cnt - tx0, 0);
      check("midrst_led_after", led, 8'h00);

      // Reset while waiting in RESP drops the response
      tx_busy = 1'b1;
      snap();
      send_pkt(8'hA5, 8'h01, 8'h77, 8'h76);
      settle(4);
      @(negedge clk);
      rst = 1'b1;
      settle(2);
      rst = 1'b0;
      tx_busy = 1'b0;
      settle(10);
      check("resp_rst_txcnt", tx_cnt - tx0, 0);
      check("resp_rst_led", led, 8'h00);

      snap();
      send_pkt(8'hA5, 8'h01, 8'h77, 8'h76);
      settle(8);
      check("final_led", led, 8'h77);
      check("final_txcnt", tx_cnt - tx0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
